// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: commit-stage trap/return flags, CSR inputs and fetch redirect handshake
// master: commit stage / CSR file / fetch side (drives flags and CSRs, accepts redirect)
// slave:  trap_sequencer (drives hold, commit pulses, cause/tval and redirect)
interface trap_sequencer_if #(parameter int XLEN = 64);
  logic            valid;
  logic [XLEN-1:0] ins_pc;
  logic [31:0]     ins_word;
  logic [XLEN-1:0] bad_addr;
  logic            ins_page_fault, ins_acc_fault, ill_ins, ins_addr_mis, ecall, ebreak;
  logic            ld_addr_mis, st_addr_mis, ld_page_fault, st_page_fault, ld_acc_fault, st_acc_fault;
  logic            m_ret, s_ret;
  logic [1:0]      priv;
  logic [15:0]     medeleg;
  logic [XLEN-1:0] mtvec, stvec, mepc, sepc;
  logic            drain_done, fetch_ack;
  logic            hold, trap_target_m, trap_target_s, ret_m, ret_s;
  logic [XLEN-1:0] cause, tval;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output valid, ins_pc, ins_word, bad_addr, ins_page_fault, ins_acc_fault, ill_ins, ins_addr_mis,
           ecall, ebreak, ld_addr_mis, st_addr_mis, ld_page_fault, st_page_fault, ld_acc_fault,
           st_acc_fault, m_ret, s_ret, priv, medeleg, mtvec, stvec, mepc, sepc, drain_done, fetch_ack,
    input  hold, trap_target_m, trap_target_s, ret_m, ret_s, cause, tval, redirect_valid, redirect_pc
  );
  modport slave (
    input  valid, ins_pc, ins_word, bad_addr, ins_page_fault, ins_acc_fault, ill_ins, ins_addr_mis,
           ecall, ebreak, ld_addr_mis, st_addr_mis, ld_page_fault, st_page_fault, ld_acc_fault,
           st_acc_fault, m_ret, s_ret, priv, medeleg, mtvec, stvec, mepc, sepc, drain_done, fetch_ack,
    output hold, trap_target_m, trap_target_s, ret_m, ret_s, cause, tval, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: commit-end exception/xRET sequencer (IDLE -> DRAIN -> COMMIT -> REDIRECT)
// Ports: clk, rst (sync, active-high), bus (trap_sequencer_if.slave: commit flags, CSRs,
//        drain_done/fetch_ack in; hold, commit pulses, cause/tval, redirect valid/pc out).
// Macro TRAP_DELEG_EN: enables medeleg delegation to S and SRET; otherwise all traps go to M
//        and SRET is raised as an illegal instruction.
module trap_sequencer #(parameter int XLEN = 64) (
  input logic clk,
  input logic rst,
  trap_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIR} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d, tval_q, tval_d, pc_q, pc_d, exc_tval, vec, epc;
  logic ret_q, ret_d, sel_s_q, sel_s_d;
  logic ill, exc, sret, ev, deleg;
  logic [3:0] code;
`ifdef TRAP_DELEG_EN
  assign ill = bus.ill_ins;
  assign sret = bus.s_ret;
  assign deleg = (bus.priv != 2'd3) & bus.medeleg[code];
  assign vec = sel_s_q ? bus.stvec : bus.mtvec;
  assign epc = sel_s_q ? bus.sepc : bus.mepc;
`else
  assign ill = bus.ill_ins | bus.s_ret;
  assign sret = 1'b0;
  assign deleg = 1'b0;
  assign vec = bus.mtvec;
  assign epc = bus.mepc;
`endif
  assign exc = bus.ins_page_fault | bus.ins_acc_fault | ill | bus.ins_addr_mis | bus.ecall | bus.ebreak |
               bus.st_addr_mis | bus.ld_addr_mis | bus.st_page_fault | bus.ld_page_fault |
               bus.st_acc_fault | bus.ld_acc_fault;
  assign ev = bus.valid & (exc | bus.m_ret | sret);
  assign code = bus.ins_page_fault ? 4'd12 :
                bus.ins_acc_fault  ? 4'd1  :
                ill                ? 4'd2  :
                bus.ins_addr_mis   ? 4'd0  :
                bus.ecall          ? 4'd8 + {2'b00, bus.priv} :
                bus.ebreak         ? 4'd3  :
                bus.st_addr_mis    ? 4'd6  :
                bus.ld_addr_mis    ? 4'd4  :
                bus.st_page_fault  ? 4'd15 :
                bus.ld_page_fault  ? 4'd13 :
                bus.st_acc_fault   ? 4'd7  : 4'd5;
  assign exc_tval = (bus.ins_page_fault | bus.ins_acc_fault) ? bus.ins_pc :
                    ill              ? {{(XLEN-32){1'b0}}, bus.ins_word} :
                    bus.ins_addr_mis ? bus.ins_pc :
                    bus.ecall        ? '0 :
                    bus.ebreak       ? bus.ins_pc : bus.bad_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      tval_q <= '0;
      pc_q <= '0;
      ret_q <= 1'b0;
      sel_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tval_q <= tval_d;
      pc_q <= pc_d;
      ret_q <= ret_d;
      sel_s_q <= sel_s_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE   ? (ev ? DRAIN : IDLE) :
              state_q == DRAIN  ? (bus.drain_done ? COMMIT : DRAIN) :
              state_q == COMMIT ? REDIR : (bus.fetch_ack ? IDLE : REDIR);
  end
  // Event attributes are captured on IDLE->DRAIN; the redirect target is captured in COMMIT
  // so it stays stable for the whole REDIRECT handshake.
  always_comb begin
    cause_d = cause_q;
    tval_d = tval_q;
    ret_d = ret_q;
    sel_s_d = sel_s_q;
    pc_d = pc_q;
    if (state_q == IDLE && ev) begin
      cause_d = exc ? {{(XLEN-4){1'b0}}, code} : '0;
      tval_d = exc ? exc_tval : '0;
      ret_d = ~exc;
      sel_s_d = exc ? deleg : ~bus.m_ret;
    end
    if (state_q == COMMIT) pc_d = ret_q ? epc : {vec[XLEN-1:2], 2'b00};
  end
  always_comb begin
    bus.hold = state_q != IDLE;
    bus.trap_target_m = (state_q == COMMIT) & ~ret_q & ~sel_s_q;
    bus.ret_m = (state_q == COMMIT) & ret_q & ~sel_s_q;
`ifdef TRAP_DELEG_EN
    bus.trap_target_s = (state_q == COMMIT) & ~ret_q & sel_s_q;
    bus.ret_s = (state_q == COMMIT) & ret_q & sel_s_q;
`else
    bus.trap_target_s = 1'b0;
    bus.ret_s = 1'b0;
`endif
    bus.redirect_valid = state_q == REDIR;
    bus.redirect_pc = pc_q;
    bus.cause = cause_q;
    bus.tval = tval_q;
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed self-checking bench for trap_sequencer
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [3:0] pulses;
  trap_sequencer_if #(.XLEN(64)) bus();
  trap_sequencer #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign pulses = {bus.trap_target_m, bus.trap_target_s, bus.ret_m, bus.ret_s};
  localparam logic [63:0] MTVEC = 64'h0000_0000_8000_0003, MBASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] STVEC = 64'h0000_0000_4000_0102, SBASE = 64'h0000_0000_4000_0100;
  localparam logic [63:0] MEPC = 64'h0000_0000_8000_2000, SEPC = 64'h0000_0000_8000_3000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    bus.valid = 0;
    {bus.ins_page_fault, bus.ins_acc_fault, bus.ill_ins, bus.ins_addr_mis, bus.ecall, bus.ebreak} = '0;
    {bus.ld_addr_mis, bus.st_addr_mis, bus.ld_page_fault, bus.st_page_fault, bus.ld_acc_fault, bus.st_acc_fault} = '0;
    bus.m_ret = 0;
    bus.s_ret = 0;
  endtask

  // Presents the already-set flags with valid for one cycle; returns in cycle N+1.
  task automatic fire();
    bus.valid = 1;
    tick();
    clear_ev();
  endtask

  task automatic ack();
    bus.fetch_ack = 1;
    tick();
    bus.fetch_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++; if (bus.hold !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0", bus.hold); end
    checks++; if (pulses !== 4'b0) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", pulses); end
    checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rv got=%b exp=0", bus.redirect_valid); end
    checks++; if ({bus.cause, bus.tval, bus.redirect_pc} !== '0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus.cause, bus.tval, bus.redirect_pc); end
    rst = 0;
    tick();
  endtask

  task automatic test_valid_low();
    bus.ill_ins = 1;
    bus.ecall = 1;
    tick();
    tick();
    checks++; if (bus.hold !== 1'b0) begin failures++; $display("FAIL vlow_hold got=%b exp=0", bus.hold); end
    clear_ev();
  endtask

  task automatic test_illegal();
    bus.priv = 3;
    bus.ins_pc = 64'h8000_0100;
    bus.ins_word = 32'hFFFF_FFFF;
    bus.ill_ins = 1;
    bus.drain_done = 1;
    fire();
    checks++; if (bus.hold !== 1'b1) begin failures++; $display("FAIL ill_hold1 got=%b exp=1", bus.hold); end
    checks++; if (pulses !== 4'b0) begin failures++; $display("FAIL ill_pulse_early got=%b exp=0000", pulses); end
    tick();
    checks++; if (pulses !== 4'b1000) begin failures++; $display("FAIL ill_pulse got=%b exp=1000", pulses); end
    checks++; if (bus.cause !== 64'd2) begin failures++; $display("FAIL ill_cause got=%0h exp=2", bus.cause); end
    checks++; if (bus.tval !== 64'hFFFF_FFFF) begin failures++; $display("FAIL ill_tval got=%h exp=ffffffff", bus.tval); end
    tick();
    checks++; if (pulses !== 4'b0) begin failures++; $display("FAIL ill_pulse_len got=%b exp=0000", pulses); end
    checks++; if (bus.redirect_valid !== 1'b1 || bus.hold !== 1'b1) begin failures++; $display("FAIL ill_rv got=%b hold=%b exp=1/1", bus.redirect_valid, bus.hold); end
    checks++; if (bus.redirect_pc !== MBASE) begin failures++; $display("FAIL ill_rpc got=%h exp=%h", bus.redirect_pc, MBASE); end
    ack();
    checks++; if (bus.hold !== 1'b0 || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL ill_done hold=%b rv=%b exp=0/0", bus.hold, bus.redirect_valid); end
    checks++; if (bus.cause !== 64'd2) begin failures++; $display("FAIL ill_cause_held got=%0h exp=2", bus.cause); end
  endtask

  task automatic test_deleg_ld_pf();
    bus.priv = 0;
    bus.medeleg = 16'h2000;
    bus.bad_addr = 64'h4000_1238;
    bus.ld_page_fault = 1;
    fire();
    tick();
`ifdef TRAP_DELEG_EN
    checks++; if (pulses !== 4'b0100) begin failures++; $display("FAIL dlpf_pulse got=%b exp=0100", pulses); end
`else
    checks++; if (pulses !== 4'b1000) begin failures++; $display("FAIL dlpf_pulse got=%b exp=1000", pulses); end
`endif
    checks++; if (bus.cause !== 64'd13) begin failures++; $display("FAIL dlpf_cause got=%0d exp=13", bus.cause); end
    checks++; if (bus.tval !== 64'h4000_1238) begin failures++; $display("FAIL dlpf_tval got=%h exp=40001238", bus.tval); end
    tick();
`ifdef TRAP_DELEG_EN
    checks++; if (bus.redirect_pc !== SBASE) begin failures++; $display("FAIL dlpf_rpc got=%h exp=%h", bus.redirect_pc, SBASE); end
`else
    checks++; if (bus.redirect_pc !== MBASE) begin failures++; $display("FAIL dlpf_rpc got=%h exp=%h", bus.redirect_pc, MBASE); end
`endif
    ack();
    bus.priv = 3;
    bus.ld_page_fault = 1;
    fire();
    tick();
    checks++; if (pulses !== 4'b1000) begin failures++; $display("FAIL mlpf_pulse got=%b exp=1000", pulses); end
    tick();
    checks++; if (bus.redirect_pc !== MBASE) begin failures++; $display("FAIL mlpf_rpc got=%h exp=%h", bus.redirect_pc, MBASE); end
    ack();
    bus.medeleg = '0;
  endtask

  task automatic test_priority();
    bus.priv = 3;
    bus.ins_pc = 64'h8000_0200;
    bus.bad_addr = 64'h1234;
    bus.ins_acc_fault = 1;
    bus.ecall = 1;
    bus.ld_addr_mis = 1;
    fire();
    tick();
    checks++; if (bus.cause !== 64'd1) begin failures++; $display("FAIL prio_cause got=%0d exp=1", bus.cause); end
    checks++; if (bus.tval !== 64'h8000_0200) begin failures++; $display("FAIL prio_tval got=%h exp=80000200", bus.tval); end
    tick();
    ack();
    bus.ebreak = 1;
    bus.m_ret = 1;
    fire();
    tick();
    checks++; if (bus.cause !== 64'd3 || pulses !== 4'b1000) begin failures++; $display("FAIL ebrk_mret cause=%0d pulses=%b exp=3/1000", bus.cause, pulses); end
    checks++; if (bus.tval !== 64'h8000_0200) begin failures++; $display("FAIL ebrk_tval got=%h exp=80000200", bus.tval); end
    tick();
    checks++; if (bus.redirect_pc !== MBASE) begin failures++; $display("FAIL ebrk_rpc got=%h exp=%h", bus.redirect_pc, MBASE); end
    ack();
    bus.priv = 1;
    bus.ecall = 1;
    bus.st_acc_fault = 1;
    fire();
    tick();
    checks++; if (bus.cause !== 64'd9 || bus.tval !== 64'd0) begin failures++; $display("FAIL ecall_s cause=%0d tval=%h exp=9/0", bus.cause, bus.tval); end
    tick();
    ack();
    bus.priv = 3;
    bus.st_page_fault = 1;
    bus.ld_page_fault = 1;
    fire();
    tick();
    checks++; if (bus.cause !== 64'd15 || bus.tval !== 64'h1234) begin failures++; $display("FAIL spf_lpf cause=%0d tval=%h exp=15/1234", bus.cause, bus.tval); end
    tick();
    ack();
  endtask

  task automatic test_return();
    bus.drain_done = 0;
    bus.m_ret = 1;
    fire();
    for (int i = 0; i < 5; i++) begin
      checks++; if (pulses !== 4'b0 || bus.hold !== 1'b1) begin failures++; $display("FAIL mret_wait%0d pulses=%b hold=%b exp=0000/1", i, pulses, bus.hold); end
      tick();
    end
    bus.drain_done = 1;
    checks++; if (pulses !== 4'b0) begin failures++; $display("FAIL mret_wait5 got=%b exp=0000", pulses); end
    tick();
    checks++; if (pulses !== 4'b0010) begin failures++; $display("FAIL mret_pulse got=%b exp=0010", pulses); end
    checks++; if (bus.tval !== 64'd0) begin failures++; $display("FAIL mret_tval got=%h exp=0", bus.tval); end
    tick();
    checks++; if (bus.redirect_pc !== MEPC || pulses !== 4'b0) begin failures++; $display("FAIL mret_rpc got=%h pulses=%b exp=%h/0000", bus.redirect_pc, pulses, MEPC); end
    ack();
  endtask

  task automatic test_handshake();
    bus.ill_ins = 1;
    bus.ins_word = 32'h0000_0013;
    fire();
    tick();
    tick();
    bus.mtvec = 64'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== MBASE) begin failures++; $display("FAIL hs_stable%0d rv=%b pc=%h exp=1/%h", i, bus.redirect_valid, bus.redirect_pc, MBASE); end
      tick();
    end
    bus.mtvec = MTVEC;
    bus.fetch_ack = 1;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== MBASE) begin failures++; $display("FAIL hs_stable3 rv=%b pc=%h exp=1/%h", bus.redirect_valid, bus.redirect_pc, MBASE); end
    tick();
    bus.fetch_ack = 0;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.hold !== 1'b0) begin failures++; $display("FAIL hs_done rv=%b hold=%b exp=0/0", bus.redirect_valid, bus.hold); end
  endtask

  task automatic test_back_to_back();
    bus.fetch_ack = 1;
    bus.ebreak = 1;
    fire();
    tick();
    tick();
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_rv got=%b exp=1", bus.redirect_valid); end
    tick();
    checks++; if (bus.hold !== 1'b0) begin failures++; $display("FAIL b2b_drop got=%b exp=0", bus.hold); end
    bus.ld_acc_fault = 1;
    bus.bad_addr = 64'h55AA;
    fire();
    checks++; if (bus.hold !== 1'b1 || bus.cause !== 64'd5) begin failures++; $display("FAIL b2b_accept hold=%b cause=%0d exp=1/5", bus.hold, bus.cause); end
    tick();
    checks++; if (pulses !== 4'b1000 || bus.tval !== 64'h55AA) begin failures++; $display("FAIL b2b_commit pulses=%b tval=%h exp=1000/55aa", pulses, bus.tval); end
    tick();
    tick();
    bus.fetch_ack = 0;
    checks++; if (bus.hold !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", bus.hold); end
  endtask

  task automatic test_reset_redirect();
    bus.ins_addr_mis = 1;
    fire();
    tick();
    tick();
    checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL rr_rv got=%b exp=1", bus.redirect_valid); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if ({bus.hold, bus.redirect_valid, pulses} !== 6'b0) begin failures++; $display("FAIL rr_ctl hold=%b rv=%b pulses=%b exp=0", bus.hold, bus.redirect_valid, pulses); end
    checks++; if ({bus.cause, bus.tval, bus.redirect_pc} !== '0) begin failures++; $display("FAIL rr_data got=%h/%h/%h exp=0", bus.cause, bus.tval, bus.redirect_pc); end
    tick();
    checks++; if ({bus.hold, pulses} !== 5'b0) begin failures++; $display("FAIL rr_after hold=%b pulses=%b exp=0", bus.hold, pulses); end
  endtask

  task automatic test_sret();
    bus.priv = 1;
    bus.ins_word = 32'h1020_0073;
    bus.s_ret = 1;
    fire();
    tick();
`ifdef TRAP_DELEG_EN
    checks++; if (pulses !== 4'b0001) begin failures++; $display("FAIL sret_pulse got=%b exp=0001", pulses); end
    tick();
    checks++; if (bus.redirect_pc !== SEPC) begin failures++; $display("FAIL sret_rpc got=%h exp=%h", bus.redirect_pc, SEPC); end
`else
    checks++; if (pulses !== 4'b1000 || bus.cause !== 64'd2) begin failures++; $display("FAIL sret_ill pulses=%b cause=%0d exp=1000/2", pulses, bus.cause); end
    checks++; if (bus.tval !== 64'h1020_0073) begin failures++; $display("FAIL sret_tval got=%h exp=10200073", bus.tval); end
    tick();
    checks++; if (bus.redirect_pc !== MBASE) begin failures++; $display("FAIL sret_rpc got=%h exp=%h", bus.redirect_pc, MBASE); end
`endif
    ack();
    bus.priv = 0;
    bus.medeleg = 16'hFFFF;
    bus.st_addr_mis = 1;
    fire();
    tick();
`ifdef TRAP_DELEG_EN
    checks++; if (pulses !== 4'b0100 || bus.cause !== 64'd6) begin failures++; $display("FAIL deleg_all pulses=%b cause=%0d exp=0100/6", pulses, bus.cause); end
`else
    checks++; if (pulses !== 4'b1000 || bus.cause !== 64'd6) begin failures++; $display("FAIL nodeleg_all pulses=%b cause=%0d exp=1000/6", pulses, bus.cause); end
`endif
    tick();
    ack();
    bus.medeleg = '0;
    bus.priv = 3;
  endtask

  initial begin
    clear_ev();
    bus.ins_pc = '0;
    bus.ins_word = '0;
    bus.bad_addr = '0;
    bus.priv = 3;
    bus.medeleg = '0;
    bus.mtvec = MTVEC;
    bus.stvec = STVEC;
    bus.mepc = MEPC;
    bus.sepc = SEPC;
    bus.drain_done = 1;
    bus.fetch_ack = 0;
    test_reset();
    test_valid_low();
    test_illegal();
    test_deleg_ld_pf();
    test_priority();
    test_return();
    test_handshake();
    test_back_to_back();
    test_reset_redirect();
    test_sret();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
